// File: rtl/common_pkg.sv
// Shared helpers for FIFO blocks: ceil-log2 sizing and the decoded read mode.
package common_pkg;

  typedef enum logic {
    FIFO_SHOW_AHEAD,
    FIFO_REGISTERED
  } fifo_mode_e;

  // Bits needed to index 'value' distinct states; never less than 1.
  function automatic int clogb2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: synchronous write, async (show-ahead) or registered read.
module fifo_mem_sdp
  import common_pkg::*;
#(
  parameter int         DW    = 32,
  parameter int         DEPTH = 32,
  parameter fifo_mode_e MODE  = FIFO_REGISTERED,
  localparam int        AW    = clogb2_f(DEPTH)
) (
  input  logic          clk_i,
  input  logic          srst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  if (MODE == FIFO_SHOW_AHEAD) begin : g_async_rd
    logic w_unused_ok;
    assign w_unused_ok = ^{re_i, srst_ni};
    assign rdata_o     = r_mem[raddr_i];
  end else begin : g_reg_rd
    logic [DW-1:0] r_rdata;
    // Read-before-write: a full-FIFO pop+push on the same slot returns the old word.
    always_ff @(posedge clk_i) begin
      if (!srst_ni)  r_rdata <= '0;
      else if (re_i) r_rdata <= r_mem[raddr_i];
    end
    assign rdata_o = r_rdata;
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost thresholds, flush and sticky error flags.
module fifo_sync_prog
  import common_pkg::*;
#(
  parameter int    DEPTH      = 32,
  parameter int    DW         = 32,
  parameter string SHOW_AHEAD = "OFF",
  localparam int   CW         = clogb2_f(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          srst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          req_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          flush_i,
  input  logic          clr_err_i,
  input  logic [CW-1:0] afull_thr_i,
  input  logic [CW-1:0] aempty_thr_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam fifo_mode_e    MODE     = (SHOW_AHEAD == "ON") ? FIFO_SHOW_AHEAD : FIFO_REGISTERED;
  localparam int            AW       = clogb2_f(DEPTH);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (SHOW_AHEAD != "ON" && SHOW_AHEAD != "OFF") begin : g_bad_mode
    $error("fifo_sync_prog: SHOW_AHEAD must be \"ON\" or \"OFF\"");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_prog: DEPTH must be >= 2");
  end

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_udf;
  logic          w_full, w_empty, w_rd_acc, w_wr_acc, w_wr_en, w_rd_en;
  logic          w_ovf_evt, w_udf_evt;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = req_i && !w_empty;
  assign w_wr_acc = valid_i && (!w_full || w_rd_acc);
  // Flush swallows the same-cycle requests without touching memory or flags.
  assign w_wr_en   = w_wr_acc && !flush_i;
  assign w_rd_en   = w_rd_acc && !flush_i;
  assign w_ovf_evt = valid_i && !w_wr_acc && !flush_i;
  assign w_udf_evt = req_i && w_empty && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!srst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
    end
  end

  // A new error event wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (clr_err_i) r_ovf <= 1'b0;
      if (w_udf_evt)      r_udf <= 1'b1;
      else if (clr_err_i) r_udf <= 1'b0;
    end
  end

  fifo_mem_sdp #(.DW(DW), .DEPTH(DEPTH), .MODE(MODE)) u_mem (
    .clk_i   (clk_i),
    .srst_ni (srst_ni),
    .we_i    (w_wr_en),
    .waddr_i (r_wr_ptr),
    .wdata_i (data_i),
    .re_i    (w_rd_en),
    .raddr_i (r_rd_ptr),
    .rdata_o (data_o)
  );

  if (MODE == FIFO_SHOW_AHEAD) begin : g_valid_sa
    assign valid_o = !w_empty;
  end else begin : g_valid_reg
    logic r_valid;
    always_ff @(posedge clk_i) begin
      if (!srst_ni) r_valid <= 1'b0;
      else          r_valid <= w_rd_en;
    end
    assign valid_o = r_valid;
  end

  assign count_o        = r_count;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= afull_thr_i);
  assign almost_empty_o = (r_count <= aempty_thr_i);
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Scoreboard bench: four fifo_sync_prog variants share one stimulus; each test checks one of them.
module tb_fifo_sync_prog;

  logic       clk, srst_n, vld, req, flush, clr;
  logic [7:0] din;
  logic [3:0] afthr, aethr;

  // a: DEPTH=5 OFF, b: DEPTH=5 ON, c: DEPTH=4 OFF, d: DEPTH=8 ON
  logic [7:0] dat_a, dat_b, dat_c, dat_d;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [3:0] cnt_d;
  logic vo_a, fu_a, em_a, af_a, ae_a, ov_a, un_a;
  logic vo_b, fu_b, em_b, af_b, ae_b, ov_b, un_b;
  logic vo_c, fu_c, em_c, af_c, ae_c, ov_c, un_c;
  logic vo_d, fu_d, em_d, af_d, ae_d, ov_d, un_d;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_d;

  fifo_sync_prog #(.DEPTH(5), .DW(8), .SHOW_AHEAD("OFF")) u_a (
    .clk_i(clk), .srst_ni(srst_n), .valid_i(vld), .data_i(din), .req_i(req),
    .data_o(dat_a), .valid_o(vo_a), .flush_i(flush), .clr_err_i(clr),
    .afull_thr_i(afthr[2:0]), .aempty_thr_i(aethr[2:0]), .count_o(cnt_a),
    .full_o(fu_a), .empty_o(em_a), .almost_full_o(af_a), .almost_empty_o(ae_a),
    .overflow_o(ov_a), .underflow_o(un_a));

  fifo_sync_prog #(.DEPTH(5), .DW(8), .SHOW_AHEAD("ON")) u_b (
    .clk_i(clk), .srst_ni(srst_n), .valid_i(vld), .data_i(din), .req_i(req),
    .data_o(dat_b), .valid_o(vo_b), .flush_i(flush), .clr_err_i(clr),
    .afull_thr_i(afthr[2:0]), .aempty_thr_i(aethr[2:0]), .count_o(cnt_b),
    .full_o(fu_b), .empty_o(em_b), .almost_full_o(af_b), .almost_empty_o(ae_b),
    .overflow_o(ov_b), .underflow_o(un_b));

  fifo_sync_prog #(.DEPTH(4), .DW(8), .SHOW_AHEAD("OFF")) u_c (
    .clk_i(clk), .srst_ni(srst_n), .valid_i(vld), .data_i(din), .req_i(req),
    .data_o(dat_c), .valid_o(vo_c), .flush_i(flush), .clr_err_i(clr),
    .afull_thr_i(afthr[2:0]), .aempty_thr_i(aethr[2:0]), .count_o(cnt_c),
    .full_o(fu_c), .empty_o(em_c), .almost_full_o(af_c), .almost_empty_o(ae_c),
    .overflow_o(ov_c), .underflow_o(un_c));

  fifo_sync_prog #(.DEPTH(8), .DW(8), .SHOW_AHEAD("ON")) u_d (
    .clk_i(clk), .srst_ni(srst_n), .valid_i(vld), .data_i(din), .req_i(req),
    .data_o(dat_d), .valid_o(vo_d), .flush_i(flush), .clr_err_i(clr),
    .afull_thr_i(afthr), .aempty_thr_i(aethr), .count_o(cnt_d),
    .full_o(fu_d), .empty_o(em_d), .almost_full_o(af_d), .almost_empty_o(ae_d),
    .overflow_o(ov_d), .underflow_o(un_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld = 1'b0; req = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  // Reset vector of instance a: {count, empty, full, valid, ovf, udf, aempty, afull} with thr 3/1.
  task automatic test_reset();
    afthr = 4'd3; aethr = 4'd1;
    do_reset();
    n_cmp++;
    if ({cnt_a, em_a, fu_a, vo_a, ov_a, un_a, ae_a, af_a} !== {3'd0, 7'b1000010}) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=%b", {cnt_a, em_a, fu_a, vo_a, ov_a, un_a, ae_a, af_a}, {3'd0, 7'b1000010});
    end
    n_cmp++;
    if (dat_a !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h want=00", dat_a); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    sb_q.delete();
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1; din = 8'(i); sb_q.push_back(8'(i));
      tick();
    end
    vld = 1'b0;
    n_cmp++;
    if (cnt_a !== 3'd5 || fu_a !== 1'b1) begin
      n_err++; $display("FAIL fill_full got cnt=%0d full=%b want cnt=5 full=1", cnt_a, fu_a);
    end
    vld = 1'b1; din = 8'hAA;
    tick();
    vld = 1'b0;
    n_cmp++;
    if (ov_a !== 1'b1 || cnt_a !== 3'd5) begin
      n_err++; $display("FAIL overflow got ovf=%b cnt=%0d want ovf=1 cnt=5", ov_a, cnt_a);
    end
    for (int i = 0; i < 5; i++) begin
      req = 1'b1;
      tick();
      exp_d = sb_q.pop_front();
      n_cmp++;
      if (vo_a !== 1'b1 || dat_a !== exp_d) begin
        n_err++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, vo_a, dat_a, exp_d);
      end
    end
    req = 1'b0;
    n_cmp++;
    if (em_a !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b want=1", em_a); end
    tick();
    n_cmp++;
    if (vo_a !== 1'b0) begin n_err++; $display("FAIL drain_valid_drop got=%b want=0", vo_a); end
  endtask

  task automatic test_wrap();
    do_reset();
    sb_q.delete();
    for (int i = 0; i < 12; i++) begin
      vld = 1'b1; req = 1'b0; din = 8'h30 + 8'(i); sb_q.push_back(din);
      tick();
      vld = 1'b0;
      n_cmp++;
      if (vo_b !== 1'b1 || em_b !== 1'b0 || cnt_b !== 3'd1 || dat_b !== sb_q[0]) begin
        n_err++; $display("FAIL wrap_wr_%0d got v=%b e=%b c=%0d d=%h want v=1 e=0 c=1 d=%h", i, vo_b, em_b, cnt_b, dat_b, sb_q[0]);
      end
      req = 1'b1;
      exp_d = sb_q.pop_front();
      n_cmp++;
      if (dat_b !== exp_d) begin n_err++; $display("FAIL wrap_rd_%0d got=%h want=%h", i, dat_b, exp_d); end
      tick();
      req = 1'b0;
      n_cmp++;
      if (em_b !== 1'b1 || vo_b !== 1'b0) begin
        n_err++; $display("FAIL wrap_empty_%0d got e=%b v=%b want e=1 v=0", i, em_b, vo_b);
      end
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    sb_q.delete();
    for (int i = 1; i <= 4; i++) begin
      vld = 1'b1; din = 8'(i); sb_q.push_back(din);
      tick();
    end
    n_cmp++;
    if (cnt_c !== 3'd4 || fu_c !== 1'b1) begin
      n_err++; $display("FAIL frw_fill got cnt=%0d full=%b want cnt=4 full=1", cnt_c, fu_c);
    end
    vld = 1'b1; din = 8'd5; req = 1'b1; sb_q.push_back(din);
    tick();
    vld = 1'b0;
    exp_d = sb_q.pop_front();
    n_cmp++;
    if ({cnt_c, fu_c, ov_c, vo_c} !== {3'd4, 3'b101} || dat_c !== exp_d) begin
      n_err++; $display("FAIL frw_both got cnt=%0d f=%b o=%b v=%b d=%h want cnt=4 f=1 o=0 v=1 d=%h", cnt_c, fu_c, ov_c, vo_c, dat_c, exp_d);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = sb_q.pop_front();
      n_cmp++;
      if (vo_c !== 1'b1 || dat_c !== exp_d) begin
        n_err++; $display("FAIL frw_drain_%0d got v=%b d=%h want v=1 d=%h", i, vo_c, dat_c, exp_d);
      end
    end
    req = 1'b0;
    n_cmp++;
    if (em_c !== 1'b1 || ov_c !== 1'b0) begin
      n_err++; $display("FAIL frw_end got e=%b o=%b want e=1 o=0", em_c, ov_c);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    req = 1'b1;
    tick();
    n_cmp++;
    if (un_a !== 1'b1 || cnt_a !== 3'd0 || vo_a !== 1'b0) begin
      n_err++; $display("FAIL udf_set got u=%b c=%0d v=%b want u=1 c=0 v=0", un_a, cnt_a, vo_a);
    end
    clr = 1'b1;
    tick();
    n_cmp++;
    if (un_a !== 1'b1) begin n_err++; $display("FAIL udf_clr_vs_set got=%b want=1", un_a); end
    req = 1'b0;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (un_a !== 1'b0) begin n_err++; $display("FAIL udf_clear got=%b want=0", un_a); end
  endtask

  task automatic test_thresholds();
    logic e_ae, e_af;
    afthr = 4'd3; aethr = 4'd1;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin vld = 1'b1; din = 8'(k); tick(); vld = 1'b0; end
      e_ae = (k <= 1);
      e_af = (k >= 3);
      n_cmp++;
      if (cnt_d !== 4'(k) || ae_d !== e_ae || af_d !== e_af) begin
        n_err++; $display("FAIL thr_cnt%0d got c=%0d ae=%b af=%b want c=%0d ae=%b af=%b", k, cnt_d, ae_d, af_d, k, e_ae, e_af);
      end
    end
    afthr = 4'd9;
    for (int k = 5; k <= 8; k++) begin
      vld = 1'b1; din = 8'(k);
      tick();
      vld = 1'b0;
      n_cmp++;
      if (af_d !== 1'b0) begin n_err++; $display("FAIL thr_above_depth_%0d got af=%b want 0", k, af_d); end
    end
    aethr = 4'd0;
    #1;
    n_cmp++;
    if (fu_d !== 1'b1 || ae_d !== 1'b0) begin
      n_err++; $display("FAIL thr_full got f=%b ae=%b want f=1 ae=0", fu_d, ae_d);
    end
    afthr = 4'd3; aethr = 4'd1;
  endtask

  task automatic test_flush_reset();
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; din = 8'h5A + 8'(i);
      tick();
    end
    vld = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++;
    if (vo_a !== 1'b1 || dat_a !== 8'h5A || cnt_a !== 3'd2) begin
      n_err++; $display("FAIL pre_flush got v=%b d=%h c=%0d want v=1 d=5a c=2", vo_a, dat_a, cnt_a);
    end
    flush = 1'b1; vld = 1'b1; req = 1'b1; din = 8'hEE;
    tick();
    idle();
    n_cmp++;
    if ({cnt_a, em_a, ov_a, un_a, vo_a} !== {3'd0, 4'b1010}) begin
      n_err++; $display("FAIL flush got c=%0d e=%b o=%b u=%b v=%b want c=0 e=1 o=0 u=1 v=0", cnt_a, em_a, ov_a, un_a, vo_a);
    end
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; din = 8'hC0 + 8'(i);
      tick();
    end
    vld = 1'b0;
    n_cmp++;
    if (cnt_a !== 3'd3) begin n_err++; $display("FAIL refill got=%0d want=3", cnt_a); end
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    n_cmp++;
    if ({cnt_a, em_a, fu_a, vo_a, ov_a, un_a, ae_a, af_a} !== {3'd0, 7'b1000010} || dat_a !== 8'h00) begin
      n_err++; $display("FAIL mid_reset got=%b d=%h want=%b d=00", {cnt_a, em_a, fu_a, vo_a, ov_a, un_a, ae_a, af_a}, dat_a, {3'd0, 7'b1000010});
    end
  endtask

  initial begin
    srst_n = 1'b1; din = '0; afthr = 4'd3; aethr = 4'd1;
    idle();
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_full_rw();
    test_underflow();
    test_thresholds();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
